// File: rtl/stopwatch_counter_pkg.sv
// Shared stopwatch definitions.
// This package is also used by the upstream mode FSM. It holds:
//   - the mode encodings,
//   - the BCD digit limits,
//   - a helper that detects the 59 state of a mod-60 digit pair.
package stopwatch_counter_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    ADJ_MIN = 2'b01,
    ADJ_SEC = 2'b10,
    PAUSE   = 2'b11
  } mode_t;

  localparam logic [3:0] MAX_ONES = 4'd9;
  localparam logic [2:0] MAX_TENS = 3'd5;

  // The comparison is ">=" so that a forced illegal digit wraps like 9 or 5 does.
  function automatic logic at_max(input logic [3:0] ones, input logic [2:0] tens);
    return (ones >= MAX_ONES) && (tens >= MAX_TENS);
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Bundle of the stopwatch control inputs and display outputs.
// The master side (mode FSM / bench) drives:
//   - mode
//   - the two tick pulses
// The slave side (counter) returns:
//   - the four BCD digits
//   - rollover
//   - blink
interface stopwatch_counter_if;
  logic [1:0] mode;
  logic       tick_1hz;
  logic       tick_adj;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic       rollover;
  logic       blink;

  modport master (
    output mode, tick_1hz, tick_adj,
    input  sec_ones, sec_tens, min_ones, min_tens, rollover, blink
  );

  modport slave (
    input  mode, tick_1hz, tick_adj,
    output sec_ones, sec_tens, min_ones, min_tens, rollover, blink
  );
endinterface

// File: rtl/stopwatch_counter_bcd_mod60.sv
// Two-digit BCD counter, modulo 60.
// Ports:
//   clk, res_n      clock and async active-low reset
//   inc             advance by one on this clk edge
//   ones, tens      registered BCD digits
//   carry_out       high in the cycle whose increment wraps 59 -> 00
// carry_out is combinational. This lets the next stage advance on the
// same edge as the wrap.
module bcd_mod60
  import stopwatch_counter_pkg::*;
(
  input  logic       clk,
  input  logic       res_n,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [2:0] tens,
  output logic       carry_out
);

  assign carry_out = inc && at_max(ones, tens);

  // Ones wraps at 9 (or any illegal value) and carries into tens.
  // Tens wraps at 5 (or any illegal value).
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ones <= 4'd0;
      tens <= 3'd0;
    end else if (inc) begin
      if (ones >= MAX_ONES) begin
        ones <= 4'd0;
        if (tens >= MAX_TENS) tens <= 3'd0;
        else                  tens <= tens + 3'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch counter with run, pause and per-field adjust modes.
// Ports:
//   clk, res_n                    clock and async active-low reset
//   mode                          00 RUN, 01 ADJ_MIN, 10 ADJ_SEC, 11 PAUSE
//   tick_1hz                      count pulse
//   tick_adj                      adjust pulse
//   sec_ones/sec_tens             BCD seconds, registered
//   min_ones/min_tens             BCD minutes, registered
//   rollover                      one-cycle pulse when 59:59 wraps to 00:00
//   blink                         blank phase for the pair being adjusted
module stopwatch_counter
  import stopwatch_counter_pkg::*;
(
  input  logic       clk,
  input  logic       res_n,
  input  logic [1:0] mode,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       rollover,
  output logic       blink
);

  mode_t cur_mode;
  logic  run, adj_min, adj_sec;
  logic  armed;
  logic  sec_inc, min_inc, sec_carry, min_carry;

  assign cur_mode = mode_t'(mode);
  assign run      = (cur_mode == RUN);
  assign adj_min  = (cur_mode == ADJ_MIN);
  assign adj_sec  = (cur_mode == ADJ_SEC);

  // armed stays low through the first edge after reset release.
  // Any tick arriving on that edge is therefore dropped.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Seconds wrap into minutes only in RUN.
  // An adjusted seconds field wraps on its own.
  assign sec_inc = armed && ((run && tick_1hz) || (adj_sec && tick_adj));
  assign min_inc = armed && ((run && sec_carry) || (adj_min && tick_adj));

  bcd_mod60 u_sec (
    .clk       (clk),
    .res_n     (res_n),
    .inc       (sec_inc),
    .ones      (sec_ones),
    .tens      (sec_tens),
    .carry_out (sec_carry)
  );

  bcd_mod60 u_min (
    .clk       (clk),
    .res_n     (res_n),
    .inc       (min_inc),
    .ones      (min_ones),
    .tens      (min_tens),
    .carry_out (min_carry)
  );

  // A minutes wrap is a rollover only in RUN.
  // An adjust wrap (59 -> 00 minutes) is silent.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) rollover <= 1'b0;
    else        rollover <= run && min_carry;
  end

  // blink alternates with each adjust tick.
  // It is held off whenever the mode is not an adjust mode.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)                  blink <= 1'b0;
    else if (!adj_min && !adj_sec) blink <= 1'b0;
    else if (armed && tick_adj)  blink <= ~blink;
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter.
// - The driver pushes expected digits from an arithmetic minutes/seconds model.
// - A monitor pops one expectation after every clk edge and compares it.
module tb_stopwatch_counter;
  import stopwatch_counter_pkg::*;

  logic clk = 1'b0;
  logic res_n = 1'b0;

  stopwatch_counter_if bus();

  stopwatch_counter dut (
    .clk      (clk),
    .res_n    (res_n),
    .mode     (bus.mode),
    .tick_1hz (bus.tick_1hz),
    .tick_adj (bus.tick_adj),
    .sec_ones (bus.sec_ones),
    .sec_tens (bus.sec_tens),
    .min_ones (bus.min_ones),
    .min_tens (bus.min_tens),
    .rollover (bus.rollover),
    .blink    (bus.blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int s;
    bit roll;
    bit blk;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model_m = 0;
  int   model_s = 0;
  bit   model_blink = 1'b0;
  bit   skip_ticks  = 1'b0;

  // Drive one cycle of inputs at the falling edge.
  // Advance the model and queue the expected post-edge state.
  task automatic applyStimulus(input mode_t md, input bit t1, input bit ta);
    exp_t e;
    @(negedge clk);
    bus.mode     = md;
    bus.tick_1hz = t1;
    bus.tick_adj = ta;
    e.roll = 1'b0;
    if (!skip_ticks) begin
      if (md == RUN && t1) begin
        model_s = model_s + 1;
        if (model_s == 60) begin
          model_s = 0;
          model_m = model_m + 1;
          if (model_m == 60) begin
            model_m = 0;
            e.roll  = 1'b1;
          end
        end
      end else if (md == ADJ_MIN && ta) begin
        model_m = (model_m + 1) % 60;
      end else if (md == ADJ_SEC && ta) begin
        model_s = (model_s + 1) % 60;
      end
    end
    if (md == RUN || md == PAUSE)  model_blink = 1'b0;
    else if (ta && !skip_ticks)    model_blink = ~model_blink;
    skip_ticks = 1'b0;
    e.m   = model_m;
    e.s   = model_s;
    e.blk = model_blink;
    exp_q.push_back(e);
  endtask

  // Issue n ticks of one kind, separated by random idle gaps.
  task automatic pulses(input mode_t md, input int n, input bit use_1hz);
    for (int i = 0; i < n; i++) begin
      applyStimulus(md, use_1hz, !use_1hz);
      for (int g = 0; g < int'($urandom_range(0, 1)); g++)
        applyStimulus(md, 1'b0, 1'b0);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Direct check of DUT outputs against fixed scenario values.
  task automatic checkOutput(input string name, input int em, input int es,
                             input bit eroll, input bit eblk);
    int am, as_;
    am  = int'(bus.min_tens) * 10 + int'(bus.min_ones);
    as_ = int'(bus.sec_tens) * 10 + int'(bus.sec_ones);
    total++;
    if (am != em || as_ != es || bus.rollover != eroll || bus.blink != eblk) begin
      bad++;
      $display("[TB] FAIL %s: got %02d:%02d roll=%0b blink=%0b, want %02d:%02d roll=%0b blink=%0b",
               name, am, as_, bus.rollover, bus.blink, em, es, eroll, eblk);
    end
  endtask

  // Monitor: after every edge, compare against the queued expectation.
  initial begin
    exp_t e;
    int am, as_;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        am  = int'(bus.min_tens) * 10 + int'(bus.min_ones);
        as_ = int'(bus.sec_tens) * 10 + int'(bus.sec_ones);
        total++;
        if (bus.min_tens > 3'd5 || bus.min_ones > 4'd9 || bus.sec_tens > 3'd5 ||
            bus.sec_ones > 4'd9 || am != e.m || as_ != e.s ||
            bus.rollover != e.roll || bus.blink != e.blk) begin
          bad++;
          $display("[TB] FAIL cycle_check t=%0t: got %0d%0d:%0d%0d roll=%0b blink=%0b, want %02d:%02d roll=%0b blink=%0b",
                   $time, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
                   bus.rollover, bus.blink, e.m, e.s, e.roll, e.blk);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.mode     = 2'b00;
    bus.tick_1hz = 1'b0;
    bus.tick_adj = 1'b0;
    #8;
    checkOutput("reset_state", 0, 0, 1'b0, 1'b0);
    res_n = 1'b1;

    // Tick on the release edge must be ignored.
    skip_ticks = 1'b1;
    applyStimulus(RUN, 1'b1, 1'b1);

    pulses(RUN, 75, 1'b1);
    settle();
    checkOutput("run_75", 1, 15, 1'b0, 1'b0);

    pulses(ADJ_MIN, 57, 1'b0);
    pulses(ADJ_SEC, 15, 1'b0);
    settle();
    checkOutput("preload_58_30", 58, 30, 1'b0, model_blink);
    pulses(ADJ_MIN, 3, 1'b0);
    settle();
    checkOutput("adj_min_wrap", 1, 30, 1'b0, model_blink);
    pulses(ADJ_SEC, 28, 1'b0);
    pulses(ADJ_SEC, 3, 1'b0);
    settle();
    checkOutput("adj_sec_wrap", 1, 1, 1'b0, model_blink);

    pulses(ADJ_MIN, 11, 1'b0);
    pulses(ADJ_SEC, 33, 1'b0);
    for (int i = 0; i < 15; i++)
      applyStimulus(PAUSE, i < 10, i >= 10);
    settle();
    checkOutput("pause_hold", 12, 34, 1'b0, 1'b0);

    pulses(ADJ_MIN, 47, 1'b0);
    pulses(ADJ_SEC, 24, 1'b0);
    applyStimulus(RUN, 1'b0, 1'b0);
    applyStimulus(RUN, 1'b1, 1'b0);
    applyStimulus(RUN, 1'b1, 1'b0);
    settle();
    checkOutput("rollover_edge", 0, 0, 1'b1, 1'b0);
    applyStimulus(RUN, 1'b0, 1'b0);
    settle();
    checkOutput("rollover_one_cycle", 0, 0, 1'b0, 1'b0);

    pulses(RUN, 9, 1'b1);
    applyStimulus(RUN, 1'b1, 1'b1);
    settle();
    checkOutput("dual_tick", 0, 10, 1'b0, 1'b0);

    pulses(ADJ_MIN, 7, 1'b0);
    pulses(ADJ_SEC, 57, 1'b0);
    applyStimulus(RUN, 1'b0, 1'b0);
    settle();
    checkOutput("at_07_07", 7, 7, 1'b0, 1'b0);

    // Reset between edges: the outputs must clear without waiting for clk.
    #1 res_n = 1'b0;
    #1 checkOutput("async_reset", 0, 0, 1'b0, 1'b0);
    model_m = 0;
    model_s = 0;
    model_blink = 1'b0;
    @(posedge clk);
    #3 res_n = 1'b1;
    skip_ticks = 1'b1;
    applyStimulus(RUN, 1'b1, 1'b0);
    applyStimulus(RUN, 1'b1, 1'b0);
    settle();
    checkOutput("after_reset_tick", 0, 1, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++)
      applyStimulus(mode_t'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0);
    applyStimulus(RUN, 1'b0, 1'b0);
    settle();
    settle();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge system clock; the only clock.
REQ-002 SHALL have port: res_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: mode  input  2  registered mode from the upstream mode FSM: 00 RUN, 01 ADJ_MIN, 10 ADJ_SEC, 11 PAUSE.
REQ-004 SHALL have port: tick_1hz  input  1  single-cycle count-enable pulse, 1 Hz.
REQ-005 SHALL have port: tick_adj  input  1  single-cycle adjust-enable pulse, 2 Hz.
REQ-006 SHALL have port: sec_ones  output  4  BCD seconds units, 0-9.
REQ-007 SHALL have port: sec_tens  output  3  BCD seconds tens, 0-5.
REQ-008 SHALL have port: min_ones  output  4  BCD minutes units, 0-9.
REQ-009 SHALL have port: min_tens  output  3  BCD minutes tens, 0-5.
REQ-010 SHALL have port: rollover  output  1  one-cycle pulse on the 59:59 -> 00:00 wrap.
REQ-011 SHALL have port: blink  output  1  display blank-phase flag for the digit pair being adjusted.

Function
REQ-012 All outputs SHALL be registered; each digit update SHALL become visible on the first clk edge at which the enabling tick is sampled high (latency 1 cycle).
REQ-013 RUN: each tick_1hz SHALL increment MM:SS by one second, with sec_ones 9->0 carrying into sec_tens, sec_tens 5->0 into min_ones, min_ones 9->0 into min_tens, and min_tens 5->0 wrapping to 00:00.
REQ-014 RUN wrap from 59:59 SHALL produce 00:00 and assert rollover high for exactly one cycle, coincident with 00:00 appearing.
REQ-015 PAUSE: all digits SHALL hold; tick_1hz and tick_adj SHALL be ignored.
REQ-016 ADJ_MIN: each tick_adj SHALL increment minutes modulo 60 (59->00); seconds hold; no rollover; tick_1hz ignored.
REQ-017 ADJ_SEC: each tick_adj SHALL increment seconds modulo 60 (59->00) with no carry into minutes; no rollover; tick_1hz ignored.
REQ-018 Simultaneous tick_1hz and tick_adj SHALL act only per the current mode; ticks SHALL never count twice.
REQ-019 The mode sampled on the same edge as a tick SHALL govern that tick; a mode change needs no settling cycle and SHALL NOT alter digits by itself.
REQ-020 blink SHALL toggle on each tick_adj while mode is ADJ_MIN or ADJ_SEC, and SHALL be forced to 0 on the first edge in RUN or PAUSE.
REQ-021 Illegal BCD digit values are unreachable; if forced, the next increment SHALL load 0 into that digit and carry.

Reset
REQ-022 res_n low SHALL asynchronously force all digits to 0, rollover to 0, and blink to 0, regardless of clk.
REQ-023 Reset asserted mid-count or mid-adjust SHALL discard state; after release, the first tick SHALL count from 00:00.
REQ-024 Ticks coinciding with the edge on which res_n deasserts SHALL be ignored.

Structure
REQ-025 Mode encodings (RUN, ADJ_MIN, ADJ_SEC, PAUSE) and constants MAX_ONES=9 and MAX_TENS=5 SHALL live in the shared stopwatch package/include, common with the upstream mode FSM.
REQ-026 One sub-module, bcd_mod60 (inputs inc, clk, res_n; outputs ones, tens, carry_out, pulsed at 59->00), SHALL be instantiated twice, for seconds and for minutes.
REQ-027 The top level SHALL contain only mode decode, the enable/carry gating, and the rollover and blink registers.

Verification
REQ-028 Reset, RUN, 75 tick_1hz pulses -> 01:15; rollover never asserted.
REQ-029 Preload 59:58 in RUN, 2 ticks -> 59:59 then 00:00, with rollover high exactly one cycle.
REQ-030 At 12:34, PAUSE, 10 tick_1hz and 5 tick_adj -> 12:34 held, blink=0.
REQ-031 At 58:30, ADJ_MIN, 3 tick_adj -> 01:30; ADJ_SEC from 01:58, 3 tick_adj -> 01:01; minutes unchanged; blink toggles 3 times.
REQ-032 Assert res_n low at 07:07 in RUN between clk edges -> outputs 00:00 immediately; after release, one tick -> 00:01.
REQ-033 RUN with tick_1hz and tick_adj high in the same cycle from 00:09 -> 00:10 (single increment).
